// File: rtl/pke_in_arb_pkg.sv
// Shared definitions for the packet-atomic PKE input arbiter: beat tags,
// FSM states, beat width and the inport metadata field bounds.
package pke_in_arb_pkg;

  localparam int PKT_W     = 134;
  localparam int TAG_HI    = 133;
  localparam int TAG_LO    = 132;
  localparam int INPORT_HI = 125;
  localparam int INPORT_LO = 120;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef logic [PKT_W-1:0] pkt_beat_t;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    TRANS_S = 2'd1,
    DROP_S  = 2'd2
  } arb_state_e;

  function automatic logic [1:0] beat_tag(input pkt_beat_t beat);
    return beat[TAG_HI:TAG_LO];
  endfunction

endpackage

// File: rtl/pke_in_arb_if.sv
// Ingress FIFO pairs, PKE output stream and counters of pke_in_arb.
// master = ingress/downstream environment, slave = the arbiter.
interface pke_in_arb_if;
  import pke_in_arb_pkg::*;

  pkt_beat_t   in_arb_data [4];
  logic [3:0]  in_arb_data_empty;
  logic [3:0]  out_arb_data_rd;
  logic [3:0]  in_arb_valid_empty;
  logic [3:0]  out_arb_valid_rd;
  logic        in_pke_alf;
  pkt_beat_t   out_pke_data;
  logic        out_pke_data_wr;
  logic        out_pke_valid;
  logic        out_pke_valid_wr;
  logic [63:0] esw_arb_pkt_cnt;
  logic [15:0] esw_arb_err_cnt;

  modport master (
    output in_arb_data, in_arb_data_empty, in_arb_valid_empty, in_pke_alf,
    input  out_arb_data_rd, out_arb_valid_rd, out_pke_data, out_pke_data_wr,
           out_pke_valid, out_pke_valid_wr, esw_arb_pkt_cnt, esw_arb_err_cnt
  );

  modport slave (
    input  in_arb_data, in_arb_data_empty, in_arb_valid_empty, in_pke_alf,
    output out_arb_data_rd, out_arb_valid_rd, out_pke_data, out_pke_data_wr,
           out_pke_valid, out_pke_valid_wr, esw_arb_pkt_cnt, esw_arb_err_cnt
  );

endinterface

// File: rtl/pke_in_arb_rr_sel.sv
// pke_rr_sel: combinational 4-way round-robin selector; searches from
// last_i+1 (mod 4) and returns the first requester.
module pke_rr_sel (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] gnt_o,
  output logic       any_o
);

  // First requester after last_i, wrapping through all four ports
  always_comb begin
    gnt_o = 2'd0;
    any_o = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!any_o && req_i[last_i + 2'(i)]) begin
        gnt_o = last_i + 2'(i);
        any_o = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/pke_in_arb.sv
// Packet-atomic round-robin arbiter from four ingress FIFO pairs into PKE.
// Optional build macro PKE_ARB_PORT0_PRIO_EN gives port 0 strict priority.
module pke_in_arb
  import pke_in_arb_pkg::*;
#(
  parameter logic [5:0] PORT_BASE = 6'd0
) (
  input logic         clk,
  input logic         rst,
  pke_in_arb_if.slave bus
);

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic        first_q, first_d;
  pkt_beat_t   data_q, data_d;
  logic        wr_q, wr_d;
  logic        vld_q, vld_d;
  logic [63:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [3:0]  data_rd_s, valid_rd_s;
  logic [3:0]  req_s, rr_req_s;
  logic [1:0]  rr_idx_s, sel_idx_s, sel_last_s;
  logic        rr_any_s, sel_any_s;
  pkt_beat_t   beat_s;
  logic        beat_avail_s;

  assign req_s        = ~bus.in_arb_valid_empty;
  assign beat_s       = bus.in_arb_data[grant_q];
  assign beat_avail_s = ~bus.in_arb_data_empty[grant_q];

  pke_rr_sel u_rr_sel (
    .req_i  (rr_req_s),
    .last_i (last_q),
    .gnt_o  (rr_idx_s),
    .any_o  (rr_any_s)
  );

`ifdef PKE_ARB_PORT0_PRIO_EN
  assign rr_req_s = req_s & 4'b1110;

  // Port 0 bypasses the rotation and leaves last_grant untouched
  always_comb begin
    if (req_s[0]) begin
      sel_idx_s  = 2'd0;
      sel_last_s = last_q;
      sel_any_s  = 1'b1;
    end else begin
      sel_idx_s  = rr_idx_s;
      sel_last_s = rr_idx_s;
      sel_any_s  = rr_any_s;
    end
  end
`else
  assign rr_req_s   = req_s;
  assign sel_idx_s  = rr_idx_s;
  assign sel_last_s = rr_idx_s;
  assign sel_any_s  = rr_any_s;
`endif

  // Next-state, FIFO pops and next output beat
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    first_d    = first_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    vld_d      = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    data_rd_s  = 4'b0000;
    valid_rd_s = 4'b0000;
    case (state_q)
      IDLE_S: begin
        if (!bus.in_pke_alf && sel_any_s) begin
          grant_d = sel_idx_s;
          last_d  = sel_last_s;
          first_d = 1'b1;
          state_d = TRANS_S;
        end else begin
          state_d = IDLE_S;
        end
      end
      TRANS_S: begin
        if (beat_avail_s) begin
          data_rd_s[grant_q] = 1'b1;
          first_d            = 1'b0;
          if (first_q && beat_tag(beat_s) != TAG_HEAD) begin
            // A lone malformed tail beat is already the whole packet
            if (beat_tag(beat_s) == TAG_TAIL) begin
              valid_rd_s[grant_q] = 1'b1;
              err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
              state_d   = IDLE_S;
            end else begin
              state_d = DROP_S;
            end
          end else begin
            wr_d   = 1'b1;
            data_d = beat_s;
            if (first_q) begin
              data_d[INPORT_HI:INPORT_LO] = PORT_BASE + {4'd0, grant_q};
            end else begin
              data_d = beat_s;
            end
            if (beat_tag(beat_s) == TAG_TAIL) begin
              valid_rd_s[grant_q] = 1'b1;
              vld_d     = 1'b1;
              pkt_cnt_d = pkt_cnt_q + 64'd1;
              state_d   = IDLE_S;
            end else begin
              state_d = TRANS_S;
            end
          end
        end else begin
          state_d = TRANS_S;
        end
      end
      DROP_S: begin
        if (beat_avail_s) begin
          data_rd_s[grant_q] = 1'b1;
          if (beat_tag(beat_s) == TAG_TAIL) begin
            valid_rd_s[grant_q] = 1'b1;
            err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            state_d   = IDLE_S;
          end else begin
            state_d = DROP_S;
          end
        end else begin
          state_d = DROP_S;
        end
      end
      default: begin
        state_d = IDLE_S;
      end
    endcase
  end

  // State, grant bookkeeping, registered outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE_S;
      grant_q   <= 2'd0;
      last_q    <= 2'd3;
      first_q   <= 1'b0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      vld_q     <= 1'b0;
      pkt_cnt_q <= 64'd0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      first_q   <= first_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      vld_q     <= vld_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.out_arb_data_rd  = data_rd_s;
  assign bus.out_arb_valid_rd = valid_rd_s;
  assign bus.out_pke_data     = data_q;
  assign bus.out_pke_data_wr  = wr_q;
  assign bus.out_pke_valid    = vld_q;
  assign bus.out_pke_valid_wr = vld_q;
  assign bus.esw_arb_pkt_cnt  = pkt_cnt_q;
  assign bus.esw_arb_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_pke_in_arb.sv
// Self-checking bench for pke_in_arb: FIFO models, per-port scoreboard and
// a packet-level arbitration model, all advanced by one step() per cycle.
module tb_pke_in_arb;
  import pke_in_arb_pkg::*;

  localparam logic [5:0] BASE = 6'd8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pke_in_arb_if bus();

  pke_in_arb #(.PORT_BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  pkt_beat_t dq [4][$];
  pkt_beat_t exp_q [4][$];
  int        vcnt [4];
  int        vpops [4];
  int        dpops [4];
  logic      stall [4];
  int        order_q [$];
  logic      in_pkt;
  int        cur_port;
  logic      prev_vwr;
  logic [3:0] snap_rd, snap_vrd;
  logic      snap_wr;

  task automatic refresh();
    for (int p = 0; p < 4; p++) begin
      bus.in_arb_data[p]        = (dq[p].size() != 0) ? dq[p][0] : '0;
      bus.in_arb_data_empty[p]  = (dq[p].size() == 0) || stall[p];
      bus.in_arb_valid_empty[p] = (vcnt[p] == 0);
    end
  endtask

  task automatic monitor();
    pkt_beat_t d;
    pkt_beat_t e;
    d = bus.out_pke_data;
    if (bus.out_pke_data_wr) begin
      if (!in_pkt) begin
        cur_port = int'(6'(d[INPORT_HI:INPORT_LO] - BASE));
        in_pkt   = 1'b1;
        order_q.push_back(cur_port);
      end
      n_checks++;
      if (prev_vwr) begin
        n_fail++;
        $display("FAIL gap: beat written right after valid_wr, required 1 idle cycle");
      end
      n_checks++;
      if (cur_port > 3 || exp_q[cur_port].size() == 0) begin
        n_fail++;
        $display("FAIL beat: unexpected beat %h (inport %0d)", d, cur_port);
      end else begin
        e = exp_q[cur_port].pop_front();
        if (d !== e) begin
          n_fail++;
          $display("FAIL beat: port %0d got %h required %h", cur_port, d, e);
        end
      end
      n_checks++;
      if (bus.out_pke_valid_wr !== (beat_tag(d) == TAG_TAIL) || bus.out_pke_valid !== bus.out_pke_valid_wr) begin
        n_fail++;
        $display("FAIL valid_wr: got %b/%b required %b", bus.out_pke_valid_wr, bus.out_pke_valid, beat_tag(d) == TAG_TAIL);
      end
      if (beat_tag(d) == TAG_TAIL) in_pkt = 1'b0;
    end else if (bus.out_pke_valid_wr !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_wr: got 1 without a beat, required 0");
    end
    prev_vwr = bus.out_pke_valid_wr;
  endtask

  // One clock cycle: drive FIFO outputs, sample/check, then apply pops
  task automatic step();
    @(negedge clk);
    refresh();
    #1;
    snap_rd  = bus.out_arb_data_rd;
    snap_vrd = bus.out_arb_valid_rd;
    snap_wr  = bus.out_pke_data_wr;
    if (!rst) monitor();
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (snap_rd[p] === 1'b1) begin
        if (dq[p].size() == 0 || stall[p]) begin
          n_checks++; n_fail++;
          $display("FAIL pop: data FIFO %0d popped while empty", p);
        end else begin
          void'(dq[p].pop_front());
          dpops[p]++;
        end
      end
      if (snap_vrd[p] === 1'b1) begin
        if (vcnt[p] == 0) begin
          n_checks++; n_fail++;
          $display("FAIL vpop: valid FIFO %0d popped while empty", p);
        end else begin
          vcnt[p]--;
          vpops[p]++;
        end
      end
    end
    refresh();
  endtask

  task automatic do_reset();
    for (int p = 0; p < 4; p++) begin
      dq[p].delete(); exp_q[p].delete();
      vcnt[p] = 0; vpops[p] = 0; dpops[p] = 0; stall[p] = 1'b0;
    end
    order_q.delete();
    in_pkt = 1'b0; prev_vwr = 1'b0; cur_port = 0;
    bus.in_pke_alf = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic push_pkt(input int p, input int len, input bit good);
    pkt_beat_t b;
    for (int i = 0; i < len; i++) begin
      b = '0;
      b[31:0] = $urandom; b[63:32] = $urandom; b[95:64] = $urandom;
      b[127:96] = $urandom; b[131:128] = 4'($urandom);
      if (i == len - 1)  b[TAG_HI:TAG_LO] = TAG_TAIL;
      else if (i == 0)   b[TAG_HI:TAG_LO] = good ? TAG_HEAD : TAG_BODY;
      else               b[TAG_HI:TAG_LO] = ($urandom_range(0, 1) == 0) ? TAG_BODY : TAG_HEAD;
      dq[p].push_back(b);
      if (good) begin
        if (i == 0) b[INPORT_HI:INPORT_LO] = BASE + 6'(p);
        exp_q[p].push_back(b);
      end
    end
    vcnt[p]++;
  endtask

  task automatic wait_pkts(input int target, input string name);
    int k = 0;
    while (bus.esw_arb_pkt_cnt < 64'(target) && k < 500) begin
      step(); k++;
    end
    n_checks++;
    if (k >= 500) begin
      n_fail++;
      $display("FAIL %s: timeout, pkt_cnt=%0d required %0d", name, bus.esw_arb_pkt_cnt, target);
    end
    repeat (3) step();
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (exp_q[p].size() != 0) begin
        n_fail++;
        $display("FAIL %s: port %0d has %0d beats never delivered, required 0", name, p, exp_q[p].size());
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.out_pke_data !== '0 || bus.out_pke_data_wr !== 1'b0 || bus.out_pke_valid !== 1'b0 ||
        bus.out_pke_valid_wr !== 1'b0 || bus.out_arb_data_rd !== 4'd0 || bus.out_arb_valid_rd !== 4'd0 ||
        bus.esw_arb_pkt_cnt !== 64'd0 || bus.esw_arb_err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset: wr=%b vld=%b rd=%b vrd=%b pkt=%0d err=%0d required all 0",
               bus.out_pke_data_wr, bus.out_pke_valid, bus.out_arb_data_rd, bus.out_arb_valid_rd,
               bus.esw_arb_pkt_cnt, bus.esw_arb_err_cnt);
    end
  endtask

  task automatic test_single();
    logic exp_wr;
    do_reset();
    push_pkt(2, 4, 1'b1);
    for (int s = 0; s < 8; s++) begin
      step();
      exp_wr = (s >= 2 && s <= 5);
      n_checks++;
      if (snap_wr !== exp_wr) begin
        n_fail++;
        $display("FAIL single_wr: cycle %0d got %b required %b", s, snap_wr, exp_wr);
      end
      if (s == 1) begin
        n_checks++;
        if (snap_rd !== 4'b0100) begin
          n_fail++;
          $display("FAIL single_pop: got %b required 0100", snap_rd);
        end
      end
    end
    wait_pkts(1, "single");
    n_checks++;
    if (bus.esw_arb_pkt_cnt !== 64'd1 || order_q.size() != 1 || order_q[0] != 2) begin
      n_fail++;
      $display("FAIL single_cnt: pkt_cnt=%0d pkts=%0d required 1 from port 2", bus.esw_arb_pkt_cnt, order_q.size());
    end
  endtask

  task automatic test_round_robin();
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) push_pkt(p, $urandom_range(2, 5), 1'b1);
    wait_pkts(8, "rr");
    n_checks++;
    if (order_q.size() != 8) begin
      n_fail++;
      $display("FAIL rr_order: got %0d packets required 8", order_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (order_q[i] != exp_order[i]) begin
          n_fail++;
          $display("FAIL rr_order: grant %0d got port %0d required %0d", i, order_q[i], exp_order[i]);
          break;
        end
      end
    end
    n_checks++;
    if (bus.esw_arb_pkt_cnt !== 64'd8) begin
      n_fail++;
      $display("FAIL rr_cnt: got %0d required 8", bus.esw_arb_pkt_cnt);
    end
  endtask

  task automatic test_alf();
    int seen = 0;
    int k = 0;
    do_reset();
    bus.in_pke_alf = 1'b1;
    push_pkt(1, 6, 1'b1);
    repeat (10) begin
      step();
      n_checks++;
      if (snap_rd !== 4'd0 || snap_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL alf_hold: rd=%b wr=%b required 0", snap_rd, snap_wr);
      end
    end
    bus.in_pke_alf = 1'b0;
    while (seen < 2 && k < 50) begin
      step(); k++;
      if (snap_wr === 1'b1) seen++;
    end
    bus.in_pke_alf = 1'b1;
    wait_pkts(1, "alf_mid");
    bus.in_pke_alf = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    push_pkt(1, 3, 1'b0);
    push_pkt(1, 4, 1'b1);
    wait_pkts(1, "drop");
    n_checks++;
    if (bus.esw_arb_err_cnt !== 16'd1 || vpops[1] != 2 || dpops[1] != 7) begin
      n_fail++;
      $display("FAIL drop: err=%0d vpops=%0d dpops=%0d required 1/2/7", bus.esw_arb_err_cnt, vpops[1], dpops[1]);
    end
    n_checks++;
    if (order_q.size() != 1 || bus.esw_arb_pkt_cnt !== 64'd1) begin
      n_fail++;
      $display("FAIL drop_fwd: pkts=%0d cnt=%0d required 1", order_q.size(), bus.esw_arb_pkt_cnt);
    end
  endtask

  task automatic test_stall();
    int k = 0;
    do_reset();
    push_pkt(0, 6, 1'b1);
    while (dpops[0] < 2 && k < 50) begin step(); k++; end
    stall[0] = 1'b1;
    step();
    n_checks++;
    if (snap_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_pre: wr got %b required 1", snap_wr);
    end
    repeat (3) begin
      step();
      n_checks++;
      if (snap_wr !== 1'b0 || snap_rd !== 4'd0) begin
        n_fail++;
        $display("FAIL stall: wr=%b rd=%b required 0/0", snap_wr, snap_rd);
      end
    end
    stall[0] = 1'b0;
    wait_pkts(1, "stall");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset();
    push_pkt(3, 5, 1'b1);
    while (snap_wr !== 1'b1 && k < 20) begin step(); k++; end
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.out_pke_data_wr !== 1'b0 || bus.out_pke_data !== '0 || bus.out_arb_data_rd !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: wr=%b rd=%b required 0", bus.out_pke_data_wr, bus.out_arb_data_rd);
    end
    rst = 1'b0;
  endtask

  task automatic test_prio();
    int pend [4] = '{3, 0, 0, 3};
    int last = 3;
    int pick;
    int exp_order [$];
    do_reset();
    for (int r = 0; r < 3; r++) begin
      push_pkt(0, $urandom_range(2, 4), 1'b1);
      push_pkt(3, $urandom_range(2, 4), 1'b1);
    end
    for (int n = 0; n < 6; n++) begin
      pick = -1;
`ifdef PKE_ARB_PORT0_PRIO_EN
      if (pend[0] > 0) pick = 0;
`endif
      for (int i = 1; i <= 4 && pick < 0; i++)
        if (pend[(last + i) % 4] > 0) pick = (last + i) % 4;
`ifdef PKE_ARB_PORT0_PRIO_EN
      if (pick != 0) last = pick;
`else
      last = pick;
`endif
      pend[pick]--;
      exp_order.push_back(pick);
    end
    wait_pkts(6, "prio");
    n_checks++;
    if (order_q.size() != 6) begin
      n_fail++;
      $display("FAIL prio_order: got %0d packets required 6", order_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (order_q[i] != exp_order[i]) begin
          n_fail++;
          $display("FAIL prio_order: grant %0d got port %0d required %0d", i, order_q[i], exp_order[i]);
          break;
        end
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      vcnt[p] = 0; stall[p] = 1'b0;
    end
    bus.in_pke_alf = 1'b0;
    refresh();
    test_reset();
    test_single();
    test_round_robin();
    test_alf();
    test_drop();
    test_stall();
    test_reset_mid();
    test_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pke_in_arb.md
# pke_in_arb

Packet-atomic input arbiter that shares the single PKE input stream between four ingress port FIFO pairs (134-bit data FIFO + packet-valid FIFO, store-and-forward). It sits between the LCM ingress queues and `pke`, grants one whole packet at a time (round-robin), stamps the ingress port into the metadata and counts forwarded and malformed packets. Downstream almost-full gates only the start of a new packet, never a packet in flight.

## Interface
- PORT_BASE, 6'd0: offset added to the granted index when stamping inport md[125:120]
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_arb_data_0..3  in  134  FWFT data-FIFO dout per port; [133:132] 01 head, 11 body, 10 tail
- in_arb_data_empty_0..3  in  1  data FIFO empty
- out_arb_data_rd_0..3  out  1  data FIFO pop (combinational from state/grant)
- in_arb_valid_empty_0..3  in  1  valid FIFO empty (non-empty = ≥1 complete packet queued)
- out_arb_valid_rd_0..3  out  1  valid FIFO pop, one pulse per packet
- in_pke_alf  in  1  downstream almost-full
- out_pke_data  out  134  packet beat to pke
- out_pke_data_wr  out  1  beat strobe
- out_pke_valid, out_pke_valid_wr  out  1,1  packet-valid pulse with tail beat
- esw_arb_pkt_cnt  out  64  packets forwarded
- esw_arb_err_cnt  out  16  malformed packets discarded, saturating at 16'hFFFF

## Operation
- States: IDLE_S, TRANS_S, DROP_S.
- IDLE_S: if in_pke_alf=0 and any port has valid_empty=0, register grant = first requester searching from last_grant+1 (mod 4), update last_grant, go TRANS_S; else stay.
- TRANS_S: while granted data FIFO non-empty, pop it and register the beat to out_pke_data with out_pke_data_wr=1. First beat of the packet: if [133:132]≠01, do not write it, go DROP_S. Otherwise overwrite [125:120] with PORT_BASE+grant (6-bit wrap). On the tail beat (10): pulse out_arb_valid_rd of granted port and write out_pke_valid=1 / out_pke_valid_wr=1 with that beat; increment esw_arb_pkt_cnt; go IDLE_S.
- DROP_S: pop beats without writing until tail; on tail pop valid FIFO, increment esw_arb_err_cnt (saturating), go IDLE_S.
- Data FIFO empty mid-packet: no pop, no write, hold state (stall, not error).
- alf rising mid-packet: ignored; packet completes.
- Non-head beat carrying 01 mid-packet: forwarded unchanged (no resync).

## Timing
- Reset values: all outputs 0, out_pke_data 134'h0, counters 0, state IDLE_S, last_grant 2'd3 (port 0 first).
- Request seen in IDLE_S at cycle T -> first pop T+1 -> first out_pke_data_wr T+2.
- Beats stream 1/cycle with no bubbles while FIFO non-empty.
- Tail popped at X -> tail written at X+1 -> IDLE_S at X+1 -> next pop X+2; at least one idle output cycle between packets.
- Reset asserted mid-packet: next cycle IDLE_S, outputs 0; partial packet is not terminated downstream. Ingress FIFOs are not flushed by this block.
- Counters wrap (64-bit) / saturate (16-bit) with no side effects.

## Configuration
- PKE_ARB_PORT0_PRIO_EN defined: port 0 wins whenever it is requesting in IDLE_S; ports 1–3 round-robin among themselves, with last_grant updated only by grants to ports 1–3.
- Not defined: plain 4-way round-robin as above.

## Structure
- Shared package: head/body/tail tag constants (2'b01/2'b11/2'b10), state encodings, PKT_W=134, inport field bounds [125:120].
- One sub-module: pke_rr_sel, a combinational 4-way round-robin selector (req[3:0], last[1:0] -> gnt idx, any). The priority macro is applied in its wrapper logic.

## Test plan
- Single packet, port 2, 4 beats, PORT_BASE=6'd8 -> 4 writes from T+2, head [125:120]=6'd10, valid_wr with beat 4, pkt_cnt=1.
- Ports 0–3 all holding 2 packets each -> grant order 0,1,2,3,0,1,2,3 with one idle cycle between packets; pkt_cnt=8.
- in_pke_alf=1 with requests pending -> no pops; alf=1 raised in beat 2 of a 6-beat packet -> all 6 beats delivered.
- Port 1 packet whose first beat tag is 11 (3 beats) -> no writes, valid FIFO popped once, err_cnt=1; the next good packet is forwarded normally.
- Data FIFO empty for 3 cycles mid-packet -> wr held 0 for 3 cycles, then resumes; payload is intact.
- With PKE_ARB_PORT0_PRIO_EN, ports 0 and 3 both continuously requesting -> only port 0 is granted; without the macro -> grants alternate 0,3.
